// File: rtl/gf2_poly_pkg.sv
// Shared widths, FSM state type and the carry-less multiply used by the GF(2) divider/multiplier pair.
package gf2_poly_pkg;

    localparam int GF2_DIVIDEND_W = 7;
    localparam int GF2_DIVISOR_W  = 4;
    localparam int GF2_Q_W        = GF2_DIVIDEND_W - GF2_DIVISOR_W + 1;
    localparam int GF2_R_W        = GF2_DIVISOR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf2_div_state_e;

    // Carry-less product: every set quotient bit XORs in a shifted copy of b.
    function automatic logic [GF2_DIVIDEND_W-1:0] gf2_mul(
        input logic [GF2_Q_W-1:0]       a,
        input logic [GF2_DIVISOR_W-1:0] b
    );
        logic [GF2_DIVIDEND_W-1:0] acc;
        logic [GF2_DIVIDEND_W-1:0] b_ext;
        acc   = '0;
        b_ext = GF2_DIVIDEND_W'(b);
        for (int i = 0; i < GF2_Q_W; i++) begin
            if (a[i]) begin
                acc = acc ^ (b_ext << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf2_poly_divider_step.sv
// One combinational long-division step: tests r[k+R_W] and, if set, cancels it with d<<k.
module gf2_div_step #(
    parameter int DIVIDEND_W = 7,
    parameter int DIVISOR_W  = 4,
    parameter int KW         = 2
) (
    input  logic [DIVIDEND_W-1:0] r_i,
    input  logic [DIVISOR_W-1:0]  d_i,
    input  logic [KW-1:0]         k_i,
    output logic [DIVIDEND_W-1:0] r_o,
    output logic                  q_bit_o
);

    localparam int R_W = DIVISOR_W - 1;
    localparam int IW  = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    logic [IW-1:0]         idx_s;
    logic [DIVIDEND_W-1:0] d_shift_s;

    // Leading-coefficient test and conditional XOR of the aligned divisor.
    always_comb begin
        idx_s     = IW'(k_i) + IW'(R_W);
        d_shift_s = DIVIDEND_W'(d_i) << k_i;
        q_bit_o   = r_i[idx_s];
        if (q_bit_o) begin
            r_o = r_i ^ d_shift_s;
        end else begin
            r_o = r_i;
        end
    end

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) polynomial divider with valid/ready handshakes.
// Optional GF2DIV_RADIX4_EN resolves two quotient bits per RUN cycle.
module gf2_poly_divider
    import gf2_poly_pkg::*;
#(
    parameter int DIVIDEND_W = GF2_DIVIDEND_W,
    parameter int DIVISOR_W  = GF2_DIVISOR_W,
    localparam int Q_W       = DIVIDEND_W - DIVISOR_W + 1,
    localparam int R_W       = DIVISOR_W - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_W-1:0]        quotient,
    output logic [R_W-1:0]        remainder,
    output logic                  div_err
);

    localparam int KW = (Q_W > 1) ? $clog2(Q_W) : 1;

    gf2_div_state_e        state_q, state_d;
    logic [DIVIDEND_W-1:0] r_q, r_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;
    logic [Q_W-1:0]        q_q, q_d;
    logic [KW-1:0]         k_q, k_d;
    logic [Q_W-1:0]        quot_q, quot_d;
    logic [R_W-1:0]        rem_q, rem_d;
    logic                  err_q, err_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [DIVIDEND_W-1:0] s0_r_s;
    logic                  s0_bit_s;

    gf2_div_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .KW         (KW)
    ) u_step0 (
        .r_i     (r_q),
        .d_i     (d_q),
        .k_i     (k_q),
        .r_o     (s0_r_s),
        .q_bit_o (s0_bit_s)
    );

`ifdef GF2DIV_RADIX4_EN
    logic [KW-1:0]         k_m1_s;
    logic [DIVIDEND_W-1:0] s1_r_s;
    logic                  s1_bit_s;

    assign k_m1_s = k_q - KW'(1);

    // Second chained stage works on the first stage's partial remainder at k-1.
    gf2_div_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .KW         (KW)
    ) u_step1 (
        .r_i     (s0_r_s),
        .d_i     (d_q),
        .k_i     (k_m1_s),
        .r_o     (s1_r_s),
        .q_bit_o (s1_bit_s)
    );
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        k_d     = k_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor[DIVISOR_W-1]) begin
                        state_d = RUN;
                        r_d     = dividend;
                        d_d     = divisor;
                        q_d     = '0;
                        k_d     = KW'(Q_W - 1);
                    end else begin
                        // Non-monic: no steps, dividend low bits pass straight through.
                        state_d = DONE;
                        quot_d  = '0;
                        rem_d   = dividend[R_W-1:0];
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                q_d[k_q] = s0_bit_s;
`ifdef GF2DIV_RADIX4_EN
                if (k_q == KW'(0)) begin
                    r_d     = s0_r_s;
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = s0_r_s[R_W-1:0];
                    err_d   = 1'b0;
                end else begin
                    q_d[k_m1_s] = s1_bit_s;
                    r_d         = s1_r_s;
                    if (k_q == KW'(1)) begin
                        state_d = DONE;
                        quot_d  = q_d;
                        rem_d   = s1_r_s[R_W-1:0];
                        err_d   = 1'b0;
                    end else begin
                        k_d = k_q - KW'(2);
                    end
                end
`else
                r_d = s0_r_s;
                if (k_q == KW'(0)) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = s0_r_s[R_W-1:0];
                    err_d   = 1'b0;
                end else begin
                    k_d = k_q - KW'(1);
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            k_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            d_q         <= d_d;
            q_q         <= q_d;
            k_q         <= k_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_err   = err_q;

endmodule
